// File: rtl/elevator_pkg.sv
// Shared definitions for the elevator controller.
//   state_e        : FSM state encoding, also driven out on the state port
//   DEF_*          : default building geometry and timing
package elevator_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_MOVE_UP = 2'd1,
    ST_MOVE_DN = 2'd2,
    ST_DOOR    = 2'd3
  } state_e;

  localparam int DEF_NUM_FLOORS    = 4;
  localparam int DEF_TRAVEL_CYCLES = 2;
  localparam int DEF_DOOR_CYCLES   = 3;

endpackage

// File: rtl/elevator_if.sv
// Call/indicator bundle between the building and the elevator controller.
//   req        : floor-call pulses, bit i = call to floor i
//   cur_floor  : current cabin floor
//   door_open  : door open indicator
//   moving_up  : cabin travelling up
//   moving_dn  : cabin travelling down
//   pending    : latched, unserved calls
//   state      : FSM state (see elevator_pkg::state_e)
// master = building side (drives req), slave = controller side.
interface elevator_if
  import elevator_pkg::*;
#(
  parameter int NUM_FLOORS = DEF_NUM_FLOORS,
  parameter int FLOOR_W    = (NUM_FLOORS > 1) ? $clog2(NUM_FLOORS) : 1
);
  logic [NUM_FLOORS-1:0] req;
  logic [FLOOR_W-1:0]    cur_floor;
  logic                  door_open;
  logic                  moving_up;
  logic                  moving_dn;
  logic [NUM_FLOORS-1:0] pending;
  logic [1:0]            state;

  modport master (
    output req,
    input  cur_floor, door_open, moving_up, moving_dn, pending, state
  );

  modport slave (
    input  req,
    output cur_floor, door_open, moving_up, moving_dn, pending, state
  );
endinterface

// File: rtl/elevator_ctrl_dwell_timer.sv
// Down-counter used for travel and door dwell times.
//   clk, rst  : clock, synchronous active-high reset
//   load      : load strobe, takes priority over counting
//   load_val  : value loaded on the strobe
//   zero      : counter has reached zero (holds there until reloaded)
module dwell_timer #(
  parameter int W = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic         zero
);
  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = load_val;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  assign zero = (cnt_q == '0);
endmodule

// File: rtl/elevator_ctrl.sv
// SCAN-order elevator controller.
//   clk, rst : clock, synchronous active-high reset
//   bus      : elevator_if slave (req in; position/door/motion/pending/state out)
// Calls are latched into a pending bitmap; the cabin keeps its direction while
// calls remain ahead of it and reverses otherwise. All outputs come from flops.
//
//   state      | meaning
//   ST_IDLE    | stopped, door closed, choosing next action from pending
//   ST_MOVE_UP | travelling up, one floor per TRAVEL_CYCLES
//   ST_MOVE_DN | travelling down, one floor per TRAVEL_CYCLES
//   ST_DOOR    | stopped with door open for DOOR_CYCLES
module elevator_ctrl
  import elevator_pkg::*;
#(
  parameter int NUM_FLOORS    = DEF_NUM_FLOORS,
  parameter int TRAVEL_CYCLES = DEF_TRAVEL_CYCLES,
  parameter int DOOR_CYCLES   = DEF_DOOR_CYCLES
) (
  input  logic       clk,
  input  logic       rst,
  elevator_if.slave  bus
);
  localparam int FLOOR_W = (NUM_FLOORS > 1) ? $clog2(NUM_FLOORS) : 1;
  localparam int TW      = (TRAVEL_CYCLES > 1) ? $clog2(TRAVEL_CYCLES) : 1;
  localparam int DW      = (DOOR_CYCLES > 1) ? $clog2(DOOR_CYCLES) : 1;
  localparam logic [TW-1:0] TRAVEL_LOAD = TW'(TRAVEL_CYCLES - 1);
  localparam logic [DW-1:0] DOOR_LOAD   = DW'(DOOR_CYCLES - 1);

  state_e                state_q, state_d;
  logic [FLOOR_W-1:0]    cur_floor_q, cur_floor_d;
  logic [NUM_FLOORS-1:0] pending_q, pending_d;
  logic                  last_up_q, last_up_d;

  logic [NUM_FLOORS-1:0] above, below, above_nxt, below_nxt, clr_mask;
  logic [FLOOR_W-1:0]    nxt_floor;
  logic                  going_up;
  logic                  travel_load, travel_zero, door_load, door_zero;

  dwell_timer #(.W(TW)) u_travel (
    .clk(clk), .rst(rst), .load(travel_load), .load_val(TRAVEL_LOAD), .zero(travel_zero)
  );

  dwell_timer #(.W(DW)) u_door (
    .clk(clk), .rst(rst), .load(door_load), .load_val(DOOR_LOAD), .zero(door_zero)
  );

  // Floor the cabin reaches on the arrival edge of the current move.
  assign going_up  = (state_q == ST_MOVE_UP);
  assign nxt_floor = going_up ? cur_floor_q + FLOOR_W'(1) : cur_floor_q - FLOOR_W'(1);

  always_comb begin
    above     = '0;
    below     = '0;
    above_nxt = '0;
    below_nxt = '0;
    for (int i = 0; i < NUM_FLOORS; i++) begin
      above[i]     = pending_q[i] && (i > int'(cur_floor_q));
      below[i]     = pending_q[i] && (i < int'(cur_floor_q));
      above_nxt[i] = pending_q[i] && (i > int'(nxt_floor));
      below_nxt[i] = pending_q[i] && (i < int'(nxt_floor));
    end
  end

  always_comb begin
    state_d     = state_q;
    cur_floor_d = cur_floor_q;
    last_up_d   = last_up_q;
    clr_mask    = '0;
    travel_load = 1'b0;
    door_load   = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (pending_q[cur_floor_q]) begin
          state_d               = ST_DOOR;
          clr_mask[cur_floor_q] = 1'b1;
          door_load             = 1'b1;
        end else if (|above && (last_up_q || !(|below))) begin
          state_d     = ST_MOVE_UP;
          travel_load = 1'b1;
          last_up_d   = 1'b1;
        end else if (|below) begin
          state_d     = ST_MOVE_DN;
          travel_load = 1'b1;
          last_up_d   = 1'b0;
        end
      end
      ST_MOVE_UP, ST_MOVE_DN: begin
        if (travel_zero) begin
          cur_floor_d = nxt_floor;
          if (pending_q[nxt_floor]) begin
            state_d             = ST_DOOR;
            clr_mask[nxt_floor] = 1'b1;
            door_load           = 1'b1;
          end else if (going_up ? |above_nxt : |below_nxt) begin
            travel_load = 1'b1;
          end else begin
            state_d = ST_IDLE;
          end
        end
      end
      ST_DOOR: begin
        // A call for this floor while the door is open just holds it open.
        if (bus.req[cur_floor_q]) begin
          door_load = 1'b1;
        end else if (door_zero) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    pending_d = (pending_q | bus.req) & ~clr_mask;
    if (state_q == ST_DOOR) begin
      pending_d[cur_floor_q] = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      cur_floor_q <= '0;
      pending_q   <= '0;
      last_up_q   <= 1'b1;
    end else begin
      state_q     <= state_d;
      cur_floor_q <= cur_floor_d;
      pending_q   <= pending_d;
      last_up_q   <= last_up_d;
    end
  end

  assign bus.state     = state_q;
  assign bus.cur_floor = cur_floor_q;
  assign bus.pending   = pending_q;
  assign bus.door_open = (state_q == ST_DOOR);
  assign bus.moving_up = (state_q == ST_MOVE_UP);
  assign bus.moving_dn = (state_q == ST_MOVE_DN);

  a_floor_range: assert property (@(posedge clk) disable iff (rst)
    int'(cur_floor_q) < NUM_FLOORS);
  a_no_up_at_top: assert property (@(posedge clk) disable iff (rst)
    (state_q == ST_MOVE_UP) |-> (int'(cur_floor_q) != NUM_FLOORS - 1));
  a_no_dn_at_bottom: assert property (@(posedge clk) disable iff (rst)
    (state_q == ST_MOVE_DN) |-> (cur_floor_q != '0));
endmodule
